// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with NZV flag register and retire counter (option: EXMEM_FLAG_BYPASS_EN)
module ex_mem_reg #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_v,
  input  logic [RA_W-1:0]   rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] store_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [DATA_W-1:0] out_store_data,
  output logic [2:0]        flags,
  output logic [2:0]        flags_br,
  output logic [15:0]       retire_cnt
);

  logic              accept;
  logic              load;
  logic              n_flag;
  logic              z_flag;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [2:0]        flags_q, flags_d;
  logic [15:0]       cnt_q, cnt_d;

  // A flush squashes the EX instruction even while the pipe is stalled, so
  // the register loads whenever it is not held by a plain stall.
  assign accept = in_valid & ~stall & ~flush;
  assign load   = flush | ~stall;
  assign n_flag = alu_result[DATA_W-1];
  assign z_flag = (alu_result == '0);

  // Pipeline payload next state: accept copies EX, bubble clears controls.
  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    store_d     = store_q;
    if (load) begin
      valid_d     = accept;
      result_d    = alu_result;
      rd_d        = rd;
      store_d     = store_data;
      reg_write_d = accept & reg_write;
      mem_read_d  = accept & mem_read;
      mem_write_d = accept & mem_write;
    end
  end

  // Flag and retire-count next state; only accepted instructions touch them.
  always_comb begin
    flags_d = flags_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + 16'd1;
      case (opcode)
        4'b0000, 4'b0001:                   flags_d = {n_flag, z_flag, alu_v};
        4'b0010, 4'b0100, 4'b0101, 4'b0110: flags_d[1] = z_flag;
        default:                            flags_d = flags_q;
      endcase
    end
  end

  // Pipeline payload registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      store_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      store_q     <= store_d;
    end
  end

  // Architectural flags and retire counter, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
      cnt_q   <= 16'h0000;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = result_q;
  assign out_rd         = rd_q;
  assign out_reg_write  = reg_write_q;
  assign out_mem_read   = mem_read_q;
  assign out_mem_write  = mem_write_q;
  assign out_store_data = store_q;
  assign flags          = flags_q;
  assign retire_cnt     = cnt_q;

`ifdef EXMEM_FLAG_BYPASS_EN
  // Branch resolution sees the flags being written this cycle.
  assign flags_br = flags_d;
`else
  assign flags_br = flags_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - scoreboard testbench for ex_mem_reg
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid;
  logic [3:0]  opcode;
  logic [15:0] alu_result;
  logic        alu_v;
  logic [3:0]  rd;
  logic        reg_write, mem_read, mem_write;
  logic [15:0] store_data;
  logic        out_valid;
  logic [15:0] out_result;
  logic [3:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic [15:0] out_store_data;
  logic [2:0]  flags, flags_br;
  logic [15:0] retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        valid;
    logic [15:0] res;
    logic [3:0]  rd;
    logic        rw, mr, mw;
    logic [15:0] sd;
    logic [2:0]  flags;
    logic [15:0] cnt;
    logic        dchk;
  } exp_t;

  exp_t m;
  exp_t sb[$];

  always #5 clk = ~clk;

  ex_mem_reg #(.DATA_W(16), .RA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .opcode(opcode), .alu_result(alu_result), .alu_v(alu_v), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .store_data(store_data), .out_valid(out_valid), .out_result(out_result),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_store_data(out_store_data),
    .flags(flags), .flags_br(flags_br), .retire_cnt(retire_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input exp_t e);
    check("out_valid", 32'(out_valid), 32'(e.valid));
    check("out_reg_write", 32'(out_reg_write), 32'(e.rw));
    check("out_mem_read", 32'(out_mem_read), 32'(e.mr));
    check("out_mem_write", 32'(out_mem_write), 32'(e.mw));
    check("flags", 32'(flags), 32'(e.flags));
    check("retire_cnt", 32'(retire_cnt), 32'(e.cnt));
    if (e.dchk) begin
      check("out_result", 32'(out_result), 32'(e.res));
      check("out_rd", 32'(out_rd), 32'(e.rd));
      check("out_store_data", 32'(out_store_data), 32'(e.sd));
    end
  endtask

  task automatic model_clear();
    m.valid = 1'b0; m.res = 16'h0; m.rd = 4'h0; m.rw = 1'b0; m.mr = 1'b0;
    m.mw = 1'b0; m.sd = 16'h0; m.flags = 3'b000; m.cnt = 16'h0; m.dchk = 1'b1;
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [15:0] res,
                      input logic av, input logic [3:0] rdv, input logic rw,
                      input logic mr, input logic mw, input logic [15:0] sd,
                      input logic st, input logic fl);
    exp_t e;
    logic acc;
    logic [2:0] nf;
    in_valid = v; opcode = op; alu_result = res; alu_v = av; rd = rdv;
    reg_write = rw; mem_read = mr; mem_write = mw; store_data = sd;
    stall = st; flush = fl;
    acc = v && !st && !fl;
    nf = m.flags;
    if (acc) begin
      if (op == 4'h0 || op == 4'h1) nf = {res[15], (res == 16'h0), av};
      else if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) nf[1] = (res == 16'h0);
    end
    #1;
`ifdef EXMEM_FLAG_BYPASS_EN
    check("flags_br", 32'(flags_br), 32'(nf));
`else
    check("flags_br", 32'(flags_br), 32'(m.flags));
`endif
    if (fl || !st) begin
      m.valid = acc; m.rw = acc && rw; m.mr = acc && mr; m.mw = acc && mw;
      m.dchk = acc;
      if (acc) begin m.res = res; m.rd = rdv; m.sd = sd; end
    end
    m.flags = nf;
    if (acc) m.cnt = m.cnt + 16'd1;
    sb.push_back(m);
    @(posedge clk); #1;
    e = sb.pop_front();
    compare_out(e);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock.
  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    compare_out(m);
    check("rst_flags_br", 32'(flags_br), 32'(0));
    rst_n = 1'b1;
    #1;
  endtask

  // Long run of accepted RED ops to move retire_cnt quickly.
  task automatic burst(input int n);
    in_valid = 1'b1; opcode = 4'h3; alu_result = 16'h0055; alu_v = 1'b0; rd = 4'h1;
    reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0; store_data = 16'h0;
    stall = 1'b0; flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    m.cnt = m.cnt + 16'(n);
    m.valid = 1'b1; m.res = 16'h0055; m.rd = 4'h1; m.rw = 1'b1; m.mr = 1'b0;
    m.mw = 1'b0; m.sd = 16'h0; m.dchk = 1'b1;
    compare_out(m);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; opcode = 4'h0;
    alu_result = 16'h0; alu_v = 1'b0; rd = 4'h0; reg_write = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; store_data = 16'h0;
    model_clear();
    #2;
    compare_out(m);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;

    //   v  op    result     v  rd   rw mr mw store      st fl
    step(1, 4'h0, 16'h8000, 1, 4'h3, 1, 0, 0, 16'h0000, 0, 0);  // ADD -> 101
    step(1, 4'h2, 16'h0000, 0, 4'h4, 1, 0, 0, 16'h0000, 0, 0);  // XOR -> 111
    step(1, 4'h3, 16'h0000, 1, 4'h5, 1, 0, 0, 16'h0000, 0, 0);  // RED no change
    step(1, 4'h0, 16'h1234, 0, 4'h6, 1, 0, 0, 16'h0000, 0, 0);  // ADD -> 000
    step(1, 4'h0, 16'h0000, 0, 4'h7, 1, 0, 0, 16'h0000, 0, 0);  // ADD -> 010 back to back
    step(1, 4'h0, 16'h1234, 0, 4'h6, 1, 0, 0, 16'h0000, 0, 0);  // ADD -> 000
    step(1, 4'h1, 16'h0000, 0, 4'h8, 1, 0, 0, 16'h0000, 0, 0);  // SUB -> 010
    step(1, 4'h1, 16'hFFFF, 1, 4'h9, 1, 0, 0, 16'h0000, 0, 0);  // SUB -> 101
    step(1, 4'h4, 16'h8001, 1, 4'hA, 1, 0, 0, 16'h0000, 0, 0);  // SLL Z only
    step(1, 4'h5, 16'h0000, 0, 4'hB, 1, 0, 0, 16'h0000, 0, 0);  // SRA Z set
    step(1, 4'h6, 16'h0F00, 0, 4'hC, 1, 0, 0, 16'h0000, 0, 0);  // ROR Z clr
    step(1, 4'h7, 16'h0000, 0, 4'hD, 1, 0, 0, 16'h0000, 0, 0);  // PADDSB no change
    step(1, 4'h9, 16'h0000, 0, 4'hE, 0, 1, 0, 16'h0000, 0, 0);  // 1xxx load, no change
    step(1, 4'h0, 16'h0044, 0, 4'h2, 0, 0, 1, 16'hBEEF, 0, 0);  // store
    for (int i = 0; i < 3; i++)
      step(1, 4'h0, 16'(16'h1000 + i), 1, 4'(i), 1, 1, 0, 16'(16'hA000 + i), 1, 0);  // stall
    step(1, 4'h1, 16'h0000, 1, 4'h1, 1, 0, 0, 16'h0000, 1, 1);  // flush+stall bubble
    step(1, 4'h0, 16'h8000, 1, 4'h3, 1, 0, 0, 16'h0000, 0, 0);  // ADD -> 101
    step(0, 4'h0, 16'h0000, 0, 4'h3, 1, 1, 1, 16'h0000, 0, 0);  // invalid bubble
    step(1, 4'h2, 16'h0000, 0, 4'h3, 1, 0, 0, 16'h0000, 0, 1);  // flush bubble
    step(1, 4'h2, 16'h0000, 0, 4'h5, 1, 0, 0, 16'h1111, 0, 0);  // XOR -> 111
    step(1, 4'h0, 16'h0001, 0, 4'h6, 1, 0, 0, 16'h0000, 0, 0);  // ADD -> 000

    do_reset();
    step(1, 4'h1, 16'h0000, 0, 4'h7, 1, 0, 0, 16'h0000, 0, 0);  // first accept after reset
    step(1, 4'h0, 16'h7FFF, 1, 4'h8, 1, 0, 0, 16'h0000, 0, 0);

    do_reset();
    burst(16'hFFFE);
    step(1, 4'h0, 16'h0001, 0, 4'h1, 1, 0, 0, 16'h0000, 0, 0);  // 0xFFFF
    step(1, 4'h0, 16'h0002, 0, 4'h2, 1, 0, 0, 16'h0000, 0, 0);  // wrap to 0
    step(1, 4'h0, 16'h0003, 0, 4'h3, 1, 0, 0, 16'h0000, 0, 0);  // 1

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
